// File: rtl/proc_seq_pkg.sv
// Shared state encodings for the processor sequencer; the control unit
// decodes STATE against these names.
package proc_seq_pkg;

   localparam int PROC_STATE_W = 3;

   typedef enum logic [PROC_STATE_W-1:0] {
      PROC_IDLE   = 3'd0,
      PROC_FETCH  = 3'd1,
      PROC_DECODE = 3'd2,
      PROC_EXE    = 3'd3,
      PROC_MEM    = 3'd4,
      PROC_WB     = 3'd5,
      PROC_HALT   = 3'd6,
      PROC_ERR    = 3'd7
   } proc_state_e;

endpackage

// File: rtl/proc_seq_cnt.sv
// Enable counter that wraps modulo 2^W; used for cycle and retire counts.
module proc_seq_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + W'(1);
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_seq_ctrl.sv
// Five-phase processor sequencer with memory wait states, optional MEM skip,
// debug halt/single-step, bus-timeout error state and activity counters.
module proc_seq_ctrl
   import proc_seq_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 15,
   parameter int SKIP_MEM = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    NEED_MEM,
   input  logic                    MEM_READY,
   input  logic                    HALT_REQ,
   input  logic                    STEP,
   output logic [PROC_STATE_W-1:0] STATE,
   output logic                    STATE_ENTRY,
   output logic                    MEM_REQ,
   output logic                    RETIRE,
   output logic                    HALTED,
   output logic                    TIMEOUT_ERR,
   output logic [CNT_W-1:0]        CYCLE_CNT,
   output logic [CNT_W-1:0]        INST_CNT
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   proc_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              entry_q, retire_q, halted_q, terr_q;
   logic              in_mem_phase, wait_hit, cyc_en;

   assign in_mem_phase = (state_q == PROC_FETCH) || (state_q == PROC_MEM);
   // MEM_READY in the limit cycle still completes the access normally.
   assign wait_hit = (MAX_WAIT != 0) && (wait_q == WAIT_LIM) && !MEM_READY;

   always_comb begin
      state_d = state_q;
      case (state_q)
         PROC_IDLE:   state_d = PROC_FETCH;
         PROC_FETCH:  if (MEM_READY) state_d = PROC_DECODE;
                      else if (wait_hit) state_d = PROC_ERR;
         PROC_DECODE: state_d = PROC_EXE;
         PROC_EXE:    state_d = (SKIP_MEM == 0 || NEED_MEM) ? PROC_MEM : PROC_WB;
         PROC_MEM:    if (MEM_READY) state_d = PROC_WB;
                      else if (wait_hit) state_d = PROC_ERR;
         PROC_WB:     state_d = HALT_REQ ? PROC_HALT : PROC_FETCH;
         PROC_HALT:   if (!HALT_REQ || STEP) state_d = PROC_FETCH;
         PROC_ERR:    state_d = PROC_ERR;
         default:     state_d = PROC_IDLE;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q)            wait_d = '0;
      else if (in_mem_phase && !MEM_READY) wait_d = wait_q + WAIT_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= PROC_IDLE;
         wait_q   <= '0;
         entry_q  <= 1'b0;
         retire_q <= 1'b0;
         halted_q <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         entry_q  <= (state_d != state_q);
         retire_q <= (state_d == PROC_WB);
         halted_q <= (state_d == PROC_HALT);
         terr_q   <= terr_q | (state_d == PROC_ERR);
      end
   end

   assign cyc_en = !(state_q inside {PROC_IDLE, PROC_HALT, PROC_ERR});

   proc_seq_cnt #(.W(CNT_W)) u_cycle_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (cyc_en),
      .cnt_o (CYCLE_CNT)
   );

   proc_seq_cnt #(.W(CNT_W)) u_inst_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (retire_q),
      .cnt_o (INST_CNT)
   );

   assign STATE       = state_q;
   assign STATE_ENTRY = entry_q;
   assign MEM_REQ     = in_mem_phase;
   assign RETIRE      = retire_q;
   assign HALTED      = halted_q;
   assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Scoreboard bench: instructions are described as phase durations, expanded
// into an expected per-cycle trace, and checked by an independent monitor.
module tb_proc_seq_ctrl;

   localparam int CW = 6;
   localparam int MW = 15;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          NEED_MEM = 1'b0, MEM_READY = 1'b0, HALT_REQ = 1'b0, STEP = 1'b0;
   logic [2:0]    STATE;
   logic          STATE_ENTRY, MEM_REQ, RETIRE, HALTED, TIMEOUT_ERR;
   logic [CW-1:0] CYCLE_CNT, INST_CNT;

   always #5 CLK = ~CLK;

   proc_seq_ctrl #(.CNT_W(CW), .MAX_WAIT(MW), .SKIP_MEM(1)) dut (
      .CLK(CLK), .RST(RST), .NEED_MEM(NEED_MEM), .MEM_READY(MEM_READY),
      .HALT_REQ(HALT_REQ), .STEP(STEP), .STATE(STATE), .STATE_ENTRY(STATE_ENTRY),
      .MEM_REQ(MEM_REQ), .RETIRE(RETIRE), .HALTED(HALTED), .TIMEOUT_ERR(TIMEOUT_ERR),
      .CYCLE_CNT(CYCLE_CNT), .INST_CNT(INST_CNT)
   );

   typedef struct {
      logic [2:0]    st;
      logic          ent;
      logic [CW-1:0] cc;
      logic [CW-1:0] ic;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   ncyc = 0;   // active cycles since reset
   int   ninst = 0;  // retired instructions since reset

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: every cycle that has an expectation is compared mid-cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("STATE", 32'(STATE), 32'(e.st));
         chk("STATE_ENTRY", 32'(STATE_ENTRY), 32'(e.ent));
         chk("MEM_REQ", 32'(MEM_REQ), 32'(e.st == 3'd1 || e.st == 3'd4));
         chk("RETIRE", 32'(RETIRE), 32'(e.st == 3'd5));
         chk("HALTED", 32'(HALTED), 32'(e.st == 3'd6));
         chk("TIMEOUT_ERR", 32'(TIMEOUT_ERR), 32'(e.st == 3'd7));
         chk("CYCLE_CNT", 32'(CYCLE_CNT), 32'(e.cc));
         chk("INST_CNT", 32'(INST_CNT), 32'(e.ic));
      end
   end

   function automatic bit rb();
      return $urandom_range(0, 1) != 0;
   endfunction

   // One clock cycle: drive this cycle's inputs and record what the outputs
   // must show during it (state st, first cycle of a visit when first=1).
   task automatic cyc(input int st, input bit first, input bit r,
                      input bit m, input bit n, input bit h, input bit s);
      exp_t e;
      @(posedge CLK); #1;
      RST = r; MEM_READY = m; NEED_MEM = n; HALT_REQ = h; STEP = s;
      if (r) begin
         ncyc = 0; ninst = 0;
         e.st = 3'd0; e.ent = 1'b0;
      end else begin
         e.st = st[2:0]; e.ent = first;
      end
      e.cc = CW'(ncyc);
      e.ic = CW'(ninst);
      q.push_back(e);
      if (!r && st >= 1 && st <= 5) ncyc++;
      if (!r && st == 5) ninst++;
   endtask

   task automatic do_reset();
      repeat (2) cyc(0, 0, 1, rb(), rb(), rb(), rb());
      cyc(0, 0, 0, rb(), rb(), rb(), rb());
   endtask

   // FETCH or MEM visit lasting waits+1 cycles; beyond MW it times out.
   task automatic mphase(input int st, input int waits, output bit err);
      err = 1'b0;
      for (int i = 0; i <= waits && i <= MW; i++)
         cyc(st, i == 0, 0, i == waits, rb(), rb(), rb());
      if (waits > MW) begin
         err = 1'b1;
         cyc(7, 1, 0, rb(), rb(), rb(), rb());
         repeat (3) cyc(7, 0, 0, rb(), rb(), rb(), rb());
         do_reset();
      end
   endtask

   task automatic instr(input int fw, input bit nm, input int mw,
                        input bit hlt, input int hold, input bit stp);
      bit err;
      mphase(1, fw, err);
      if (err) return;
      cyc(2, 1, 0, rb(), rb(), rb(), rb());
      cyc(3, 1, 0, rb(), nm, rb(), rb());
      if (nm) begin
         mphase(4, mw, err);
         if (err) return;
      end
      cyc(5, 1, 0, rb(), rb(), hlt, rb());
      if (hlt)
         for (int i = 0; i <= hold; i++) begin
            if (i < hold)  cyc(6, i == 0, 0, rb(), rb(), 1, 0);
            else if (stp)  cyc(6, i == 0, 0, rb(), rb(), 1, 1);
            else           cyc(6, i == 0, 0, rb(), rb(), 0, rb());
         end
   endtask

   task automatic rand_instr(input bit allow_err);
      int fw, mw;
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MW) : 0;
      mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MW) : 0;
      if (allow_err && $urandom_range(0, 19) == 0) fw = MW + 1;
      if (allow_err && $urandom_range(0, 19) == 0) mw = MW + 1;
      instr(fw, rb(), mw, $urandom_range(0, 5) == 0, $urandom_range(0, 5), rb());
   endtask

   initial begin
      bit err;
      do_reset();
      repeat (8) instr(0, 0, 0, 0, 0, 0);
      instr(0, 1, 3, 0, 0, 0);
      instr(MW + 1, 0, 0, 0, 0, 0);
      instr(MW, 0, 0, 0, 0, 0);
      instr(0, 1, MW + 1, 0, 0, 0);
      instr(2, 1, MW, 0, 0, 0);
      instr(0, 0, 0, 1, 9, 1);
      instr(0, 0, 0, 1, 9, 1);
      instr(0, 0, 0, 1, 2, 0);
      instr(1, 0, 0, 0, 0, 0);
      // reset lands in the cycle that would have been EXE
      mphase(1, 0, err);
      cyc(2, 1, 0, rb(), rb(), rb(), rb());
      do_reset();
      repeat (80) rand_instr(1'b0);
      repeat (40) rand_instr(1'b1);
      @(posedge CLK); #1;
      repeat (2) @(negedge CLK);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
